addsub_seq_ctrl: RTL and testbench
==================================

ADDSUB_SEQ_CTRL -- requirements
Module: addsub_seq_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Parameter SETTLE_CYCLES, default 4: clock cycles the downstream addsub32 operands are held stable before its outputs are captured. Legal range 1..255.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operand request valid.
REQ-006 in_ready  output  1  block can accept an operand request.
REQ-007 in_a, in_b  input  32 each  operands; in_sub  input  1  1 = subtract, 0 = add.
REQ-008 adder_a, adder_b  output  32 each; adder_sub  output  1  registered drive into addsub32 A, B, SUB.
REQ-009 adder_ans  input  32; adder_cout, adder_v  input  1 each  addsub32 ans, cout, V.
REQ-010 out_valid  output  1  result valid; out_ready  input  1  consumer accepts result.
REQ-011 out_result  output  32; out_cout, out_v, out_z, out_n  output  1 each  captured result and flags.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, SETTLE, HOLD.
REQ-014 in_ready SHALL be 1 in IDLE only, 0 otherwise; no request is accepted in SETTLE or HOLD.
REQ-015 IDLE with in_valid=1 at a rising edge SHALL register in_a/in_b/in_sub into adder_a/adder_b/adder_sub, load the 8-bit settle counter with SETTLE_CYCLES-1, and enter SETTLE.
REQ-016 adder_a/adder_b/adder_sub SHALL change only on an accepted request and hold value otherwise.
REQ-017 SETTLE SHALL decrement the counter each edge; on the edge where the counter is 0 it SHALL capture adder_ans, adder_cout, adder_v into out_result/out_cout/out_v, set out_z = (adder_ans == 0), out_n = adder_ans[31], and enter HOLD.
REQ-018 Latency: request accepted at edge E0 -> out_valid high after edge E0+SETTLE_CYCLES; SETTLE_CYCLES=1 captures at E0+1.
REQ-019 out_valid SHALL be 1 in HOLD only; captured outputs SHALL stay stable while out_valid=1 and out_ready=0.
REQ-020 HOLD with out_ready=1 at an edge SHALL deassert out_valid and return to IDLE; the next request is accepted no earlier than the following edge.
REQ-021 in_valid while not in IDLE SHALL be ignored; in_ready=0 signals the upstream to hold its request.
REQ-022 Captured outputs SHALL retain last values in IDLE and SETTLE until the next capture.

Reset
REQ-023 rst_n=0 SHALL immediately, without a clock edge, force state IDLE, counter 0, in_ready=1, out_valid=0, busy=0, and adder_a, adder_b, adder_sub, out_result, out_cout, out_v, out_z, out_n to 0.
REQ-024 Reset during SETTLE or HOLD SHALL discard the in-flight operation; no out_valid pulse follows release.
REQ-025 After rst_n rises, the first request SHALL be accepted on the first edge with in_valid=1.

Configuration
REQ-026 Macro ADDSUB_STICKY_OVF_EN defined: add input ovf_clr (1) and output sticky_ovf (1); sticky_ovf sets on any capture with adder_v=1, clears on an edge with ovf_clr=1 (set wins if both occur on the same edge), resets to 0.
REQ-027 Macro undefined: ports ovf_clr and sticky_ovf SHALL not exist; all other behaviour identical.

Verification
REQ-028 SETTLE_CYCLES=4, in_a=0x00000021, in_b=0x00000022, in_sub=0 -> out_valid after 4 edges, out_result=0x00000043, cout=0, v=0, z=0, n=0.
REQ-029 in_a=0x7FFFFFFF, in_b=0x00000001, in_sub=0 -> out_result=0x80000000, out_v=1, out_n=1, out_cout=0.
REQ-030 in_a=in_b=0x336FB7E5, in_sub=1 -> out_result=0x00000000, out_z=1, out_cout=1, out_v=0.
REQ-031 out_ready held 0 for 5 cycles in HOLD -> out_valid and outputs stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next edge.
REQ-032 rst_n pulsed low mid-SETTLE -> all outputs 0 immediately, no out_valid after release, next request completes normally.
REQ-033 With ADDSUB_STICKY_OVF_EN: 0x80000000 - 0x00000001 -> sticky_ovf=1, persists through a non-overflow op (0x6FABCDE1 - 0x12345678 = 0x5D777769), clears on ovf_clr.

Source files
------------

// File: rtl/addsub_seq_ctrl.sv
// addsub_seq_ctrl: sequences one addsub32 operation (drive, settle, capture, hold).
// Optional sticky overflow flag with ovf_clr when ADDSUB_STICKY_OVF_EN is defined.
module addsub_seq_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef ADDSUB_STICKY_OVF_EN
    input  logic        ovf_clr,
    output logic        sticky_ovf,
`endif
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_sub,
    output logic [31:0] adder_a,
    output logic [31:0] adder_b,
    output logic        adder_sub,
    input  logic [31:0] adder_ans,
    input  logic        adder_cout,
    input  logic        adder_v,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_cout,
    output logic        out_v,
    output logic        out_z,
    output logic        out_n,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic        sub_q, sub_d, cout_q, cout_d, v_q, v_d, z_q, z_d, n_q, n_d;
    logic        capture;

    assign capture = (state_q == SETTLE) && (cnt_q == 8'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        res_d   = res_q;
        cout_d  = cout_q;
        v_d     = v_q;
        z_d     = z_q;
        n_d     = n_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = in_a;
                b_d     = in_b;
                sub_d   = in_sub;
                cnt_d   = 8'(SETTLE_CYCLES - 1);
                state_d = SETTLE;
            end
            SETTLE: if (capture) begin
                res_d   = adder_ans;
                cout_d  = adder_cout;
                v_d     = adder_v;
                z_d     = (adder_ans == 32'd0);
                n_d     = adder_ans[31];
                state_d = HOLD;
            end else begin
                cnt_d = cnt_q - 8'd1;
            end
            HOLD: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            v_q     <= v_d;
            z_q     <= z_d;
            n_q     <= n_d;
        end
    end

`ifdef ADDSUB_STICKY_OVF_EN
    logic sticky_q, sticky_d;

    // a capture with overflow beats a clear on the same edge
    always_comb sticky_d = (capture && adder_v) || (sticky_q && !ovf_clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sticky_q <= 1'b0;
        else        sticky_q <= sticky_d;
    end

    assign sticky_ovf = sticky_q;
`endif

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == HOLD);
    assign busy       = (state_q != IDLE);
    assign adder_a    = a_q;
    assign adder_b    = b_q;
    assign adder_sub  = sub_q;
    assign out_result = res_q;
    assign out_cout   = cout_q;
    assign out_v      = v_q;
    assign out_z      = z_q;
    assign out_n      = n_q;
endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// tb_addsub_seq_ctrl: directed checks of addsub_seq_ctrl with a behavioural addsub32.
// Define ADDSUB_STICKY_OVF_EN to also exercise the sticky overflow flag.
module tb_addsub_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_sub = 1'b0, out_ready = 1'b0;
    logic [31:0] in_a = '0, in_b = '0;
    logic        in_ready, adder_sub, out_valid, out_cout, out_v, out_z, out_n, busy;
    logic [31:0] adder_a, adder_b, adder_ans, out_result;
    logic        adder_cout, adder_v;
    logic [31:0] bb;
`ifdef ADDSUB_STICKY_OVF_EN
    logic        ovf_clr = 1'b0;
    logic        sticky_ovf;
`endif
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // downstream addsub32 model
    assign bb = adder_sub ? ~adder_b : adder_b;
    assign {adder_cout, adder_ans} = {1'b0, adder_a} + {1'b0, bb} + {32'd0, adder_sub};
    assign adder_v = (adder_a[31] == bb[31]) && (adder_ans[31] != adder_a[31]);

    addsub_seq_ctrl #(.SETTLE_CYCLES(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef ADDSUB_STICKY_OVF_EN
        .ovf_clr(ovf_clr),
        .sticky_ovf(sticky_ovf),
`endif
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .in_sub(in_sub),
        .adder_a(adder_a),
        .adder_b(adder_b),
        .adder_sub(adder_sub),
        .adder_ans(adder_ans),
        .adder_cout(adder_cout),
        .adder_v(adder_v),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_result(out_result),
        .out_cout(out_cout),
        .out_v(out_v),
        .out_z(out_z),
        .out_n(out_n),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic [31:0] er, input logic ec, input logic ev,
                         input logic ez, input logic en);
        int n;
        chk("ready_before_op", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_sub = sub;
        step();
        in_valid = 1'b0;
        chk("adder_a", adder_a, a);
        chk("adder_b", adder_b, b);
        chk("adder_sub", {31'd0, adder_sub}, {31'd0, sub});
        chk("busy_settle", {31'd0, busy}, 32'd1);
        chk("ready_settle", {31'd0, in_ready}, 32'd0);
        n = 0;
        while (!out_valid && n < 300) begin
            step();
            n++;
        end
        chk("latency", n, 32'd4);
        chk("result", out_result, er);
        chk("flags_cvzn", {28'd0, out_cout, out_v, out_z, out_n}, {28'd0, ec, ev, ez, en});
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("valid_after_ack", {31'd0, out_valid}, 32'd0);
        chk("ready_after_ack", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic seen_valid;
        #2;
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_valid_busy", {30'd0, out_valid, busy}, 32'd0);
        chk("rst_adder_a", adder_a, 32'd0);
        chk("rst_result", out_result, 32'd0);
        #10 rst_n = 1'b1;
        step();

        do_op(32'h00000021, 32'h00000022, 1'b0, 32'h00000043, 1'b0, 1'b0, 1'b0, 1'b0);
        // stall in HOLD while upstream keeps presenting a new request
        in_valid = 1'b1;
        in_a = 32'hDEADBEEF;
        in_b = 32'h12345678;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_result", out_result, 32'h00000043);
            chk("hold_adder_a", adder_a, 32'h00000021);
        end
        in_valid = 1'b0;
        release_out();
        chk("idle_keeps_result", out_result, 32'h00000043);

        do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1);
        release_out();
        do_op(32'h336FB7E5, 32'h336FB7E5, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0);
        release_out();

        // abort an operation with reset mid-SETTLE
        do_op(32'h00000005, 32'h00000003, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0, 1'b0);
        release_out();
        in_valid = 1'b1;
        in_a = 32'h00000010;
        in_b = 32'h00000020;
        in_sub = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_adder_a", adder_a, 32'd0);
        chk("mid_rst_adder_b", adder_b, 32'd0);
        chk("mid_rst_result", out_result, 32'd0);
        chk("mid_rst_flags", {28'd0, out_cout, out_v, out_z, out_n}, 32'd0);
        chk("mid_rst_ctrl", {29'd0, in_ready, out_valid, busy}, 32'b100);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            seen_valid |= out_valid;
        end
        chk("no_valid_after_rst", {31'd0, seen_valid}, 32'd0);
        do_op(32'h00000010, 32'h00000020, 1'b0, 32'h00000030, 1'b0, 1'b0, 1'b0, 1'b0);
        release_out();

`ifdef ADDSUB_STICKY_OVF_EN
        chk("sticky_init", {31'd0, sticky_ovf}, 32'd0);
        do_op(32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("sticky_set", {31'd0, sticky_ovf}, 32'd1);
        release_out();
        do_op(32'h6FABCDE1, 32'h12345678, 1'b1, 32'h5D777769, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("sticky_persist", {31'd0, sticky_ovf}, 32'd1);
        release_out();
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("sticky_clr", {31'd0, sticky_ovf}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
